// File: rtl/afe_attn_spi_driver.sv
// Serial driver for the AFE attenuator/switch shift registers: one shared shift
// engine, MSB-first, per-lane SCK/SDI/LE pins, with busy, sticky reject and last-value readback.
module afe_attn_spi_driver #(
  parameter int CLK_RATE        = 99999001,
  parameter int SPI_CLK_RATE    = 10000000,
  parameter int HALF_TICKS      = (CLK_RATE + 2 * SPI_CLK_RATE - 1) / (2 * SPI_CLK_RATE),
  parameter int DATA_WIDTH      = 16,
  parameter int CHANNEL_COUNT   = 2,
  parameter int CHSEL_WIDTH     = 1,
  parameter int LE_HALF_PERIODS = 1
) (
  input  logic                                sysClk,
  input  logic                                sysReset_n,
  input  logic                                wrStrobe,
  input  logic [CHSEL_WIDTH-1:0]              wrChannel,
  input  logic [DATA_WIDTH-1:0]               wrData,
  input  logic                                clrFlags,
  output logic                                busy,
  output logic                                rejected,
  output logic [CHANNEL_COUNT*DATA_WIDTH-1:0] lastValue,
  output logic [CHANNEL_COUNT-1:0]            AFE_SPI_CLK,
  output logic [CHANNEL_COUNT-1:0]            AFE_SPI_SDI,
  output logic [CHANNEL_COUNT-1:0]            AFE_SPI_LE
);

  localparam int HT          = (HALF_TICKS < 1) ? 1 : HALF_TICKS;
  localparam int LE_HP       = (LE_HALF_PERIODS < 1) ? 1 : LE_HALF_PERIODS;
  localparam int LATCH_TICKS = LE_HP * HT;
  localparam int DIV_W       = $clog2(LATCH_TICKS + 1);
  localparam int BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, CLKH, CLKL, LATCH, GAP} state_e;

  state_e                              state_q, state_d;
  logic [DIV_W-1:0]                    div_q, div_d;
  logic [BIT_W-1:0]                    bit_q, bit_d;
  logic [DATA_WIDTH-1:0]               sh_q, sh_d;
  logic [DATA_WIDTH-1:0]               data_q, data_d;
  logic [CHSEL_WIDTH-1:0]              chan_q, chan_d;
  logic                                busy_q, busy_d;
  logic                                rejected_q, rejected_d;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] last_q, last_d;
  logic [CHANNEL_COUNT-1:0]            sck_q, sck_d, sdi_q, sdi_d, le_q, le_d;

  logic chan_ok;
  logic phase_last;
  logic rej_set;
  logic sck_line, sdi_line, le_line;

  // When every encoding of the select field names a real lane there is nothing to range-check.
  if (CHANNEL_COUNT >= (1 << CHSEL_WIDTH)) begin : g_chan_full
    assign chan_ok = 1'b1;
  end else begin : g_chan_part
    assign chan_ok = (wrChannel < CHSEL_WIDTH'(CHANNEL_COUNT));
  end

  assign phase_last = (state_q == LATCH) ? (div_q == DIV_W'(LATCH_TICKS - 1))
                                         : (div_q == DIV_W'(HT - 1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    data_d     = data_q;
    chan_d     = chan_q;
    busy_d     = busy_q;
    last_d     = last_q;
    rej_set    = wrStrobe && ((state_q != IDLE) || !chan_ok);
    rejected_d = rej_set || (rejected_q && !clrFlags);

    if (state_q == IDLE) begin
      div_d = '0;
      if (wrStrobe && chan_ok) begin
        state_d = SETUP;
        chan_d  = wrChannel;
        data_d  = wrData;
        sh_d    = wrData;
        bit_d   = BIT_W'(DATA_WIDTH - 1);
        busy_d  = 1'b1;
      end
    end else if (!phase_last) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
      case (state_q)
        SETUP: state_d = CLKH;
        CLKH: begin
          state_d = CLKL;
          // The LSB stays on SDI through the final low phase.
          if (bit_q != '0) sh_d = sh_q << 1;
        end
        CLKL: begin
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            state_d = CLKH;
            bit_d   = bit_q - 1'b1;
          end
        end
        LATCH: state_d = GAP;
        GAP: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          for (int n = 0; n < CHANNEL_COUNT; n++) begin
            if (chan_q == CHSEL_WIDTH'(n)) last_d[n*DATA_WIDTH +: DATA_WIDTH] = data_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Pins are registered copies of what the next state implies, steered to the selected lane.
    sck_line = (state_d == CLKH);
    sdi_line = ((state_d == SETUP) || (state_d == CLKH) || (state_d == CLKL)) && sh_d[DATA_WIDTH-1];
    le_line  = (state_d == LATCH);
    sck_d    = '0;
    sdi_d    = '0;
    le_d     = '0;
    for (int n = 0; n < CHANNEL_COUNT; n++) begin
      if (chan_d == CHSEL_WIDTH'(n)) begin
        sck_d[n] = sck_line;
        sdi_d[n] = sdi_line;
        le_d[n]  = le_line;
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      chan_q     <= '0;
      busy_q     <= 1'b0;
      rejected_q <= 1'b0;
      last_q     <= '0;
      sck_q      <= '0;
      sdi_q      <= '0;
      le_q       <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      chan_q     <= chan_d;
      busy_q     <= busy_d;
      rejected_q <= rejected_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      le_q       <= le_d;
    end
  end

  assign busy        = busy_q;
  assign rejected    = rejected_q;
  assign lastValue   = last_q;
  assign AFE_SPI_CLK = sck_q;
  assign AFE_SPI_SDI = sdi_q;
  assign AFE_SPI_LE  = le_q;

endmodule

// File: tb/tb_afe_attn_spi_driver.sv
// Randomized bench for afe_attn_spi_driver: decodes each lane's serial waveform
// and compares it, plus busy/rejected/lastValue, against a transaction-level model.
module tb_afe_attn_spi_driver;

  localparam int CLK_RATE     = 99999001;
  localparam int SPI_CLK_RATE = 10000000;
  localparam int DW           = 16;
  localparam int NCH          = 2;
  localparam int LEHP         = 1;
  localparam int HT           = (CLK_RATE + 2 * SPI_CLK_RATE - 1) / (2 * SPI_CLK_RATE);
  localparam int BUSY_LEN     = HT * (2 * DW + LEHP + 2);
  localparam int LE_START     = HT * (1 + 2 * DW);

  logic              sysClk;
  logic              sysReset_n;
  logic              wrStrobe;
  logic [1:0]        wrChannel;
  logic [DW-1:0]     wrData;
  logic              clrFlags;
  logic              busy;
  logic              rejected;
  logic [NCH*DW-1:0] lastValue;
  logic [NCH-1:0]    AFE_SPI_CLK;
  logic [NCH-1:0]    AFE_SPI_SDI;
  logic [NCH-1:0]    AFE_SPI_LE;

  int vec_count  = 0;
  int miscompares = 0;

  logic [DW-1:0] model_last [NCH];
  logic          model_rej;

  afe_attn_spi_driver #(
    .CLK_RATE       (CLK_RATE),
    .SPI_CLK_RATE   (SPI_CLK_RATE),
    .DATA_WIDTH     (DW),
    .CHANNEL_COUNT  (NCH),
    .CHSEL_WIDTH    (2),
    .LE_HALF_PERIODS(LEHP)
  ) dut (
    .sysClk     (sysClk),
    .sysReset_n (sysReset_n),
    .wrStrobe   (wrStrobe),
    .wrChannel  (wrChannel),
    .wrData     (wrData),
    .clrFlags   (clrFlags),
    .busy       (busy),
    .rejected   (rejected),
    .lastValue  (lastValue),
    .AFE_SPI_CLK(AFE_SPI_CLK),
    .AFE_SPI_SDI(AFE_SPI_SDI),
    .AFE_SPI_LE (AFE_SPI_LE)
  );

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] model_last_vec();
    logic [NCH*DW-1:0] v;
    for (int n = 0; n < NCH; n++) v[n*DW +: DW] = model_last[n];
    return v;
  endfunction

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  // One transfer, observed cycle by cycle until busy drops (bounded).
  task automatic run_xfer(input logic [1:0] ch, input logic [DW-1:0] d,
                          input int rej_at, input int clr_at, input int abort_at);
    int busy_cnt = 0, rises = 0, first_rise = -1, last_rise = -1, bad_spacing = 0;
    int le_cnt = 0, le_first = -1, other_bad = 0, rej_bad = 0, quiet_bad = 0;
    logic [DW-1:0] word = '0;
    logic prev_sck = 1'b0;
    int lane = int'(ch[0]);
    logic [NCH-1:0] other_mask;
    other_mask = ~(NCH'(1) << lane);

    wrStrobe  = 1'b1;
    wrChannel = ch;
    wrData    = d;
    clrFlags  = 1'b0;
    step();
    wrStrobe = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (rejected !== model_rej) rej_bad++;
      if (!busy) break;
      busy_cnt++;
      if (AFE_SPI_CLK[lane] && !prev_sck) begin
        word = {word[DW-2:0], AFE_SPI_SDI[lane]};
        rises++;
        if (last_rise >= 0 && (cyc - last_rise) != 2 * HT) bad_spacing++;
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
      end
      if (AFE_SPI_LE[lane]) begin
        le_cnt++;
        if (le_first < 0) le_first = cyc;
      end
      if (((AFE_SPI_CLK | AFE_SPI_SDI | AFE_SPI_LE) & other_mask) != '0) other_bad++;
      prev_sck = AFE_SPI_CLK[lane];

      wrData    = DW'($urandom);
      wrChannel = 2'($urandom);
      wrStrobe  = (cyc == rej_at);
      clrFlags  = (cyc == clr_at);
      if (cyc == rej_at) model_rej = 1'b1;
      else if (cyc == clr_at) model_rej = 1'b0;

      if (cyc == abort_at) begin
        wrStrobe = 1'b0;
        clrFlags = 1'b0;
        #3 sysReset_n = 1'b0;
        #1;
        model_rej = 1'b0;
        for (int n = 0; n < NCH; n++) model_last[n] = '0;
        check_eq("abort_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, '0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_last", lastValue, model_last_vec());
        check_eq("abort_rej", rejected, model_rej);
        @(posedge sysClk);
        @(posedge sysClk);
        #3 sysReset_n = 1'b1;
        step();
        for (int k = 0; k < 200; k++) begin
          if (busy || (AFE_SPI_CLK | AFE_SPI_SDI | AFE_SPI_LE) != '0) quiet_bad++;
          step();
        end
        check_eq("abort_quiet", quiet_bad, 0);
        $display("xfer ch=%0d data=%h aborted by reset at cycle %0d", ch, d, abort_at);
        return;
      end
      step();
    end
    wrStrobe = 1'b0;
    clrFlags = 1'b0;

    model_last[lane] = d;
    check_eq("busy_len", busy_cnt, BUSY_LEN);
    check_eq("sck_rises", rises, DW);
    check_eq("word", word, d);
    check_eq("first_rise", first_rise, HT);
    check_eq("sck_spacing", bad_spacing, 0);
    check_eq("le_len", le_cnt, HT * LEHP);
    check_eq("le_start", le_first, LE_START);
    check_eq("other_lane", other_bad, 0);
    check_eq("rej_track", rej_bad, 0);
    check_eq("last_value", lastValue, model_last_vec());
    $display("xfer ch=%0d data=%h busy=%0d word=%h rej=%0b", ch, d, busy_cnt, word, rejected);
  endtask

  task automatic bad_channel(input logic [1:0] ch);
    int act = 0;
    wrStrobe  = 1'b1;
    wrChannel = ch;
    wrData    = DW'($urandom);
    step();
    wrStrobe  = 1'b0;
    model_rej = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (busy || (AFE_SPI_CLK | AFE_SPI_SDI | AFE_SPI_LE) != '0) act++;
      step();
    end
    check_eq("badch_quiet", act, 0);
    check_eq("badch_rej", rejected, model_rej);
    check_eq("badch_last", lastValue, model_last_vec());
    $display("bad channel ch=%0d rejected=%0b", ch, rejected);
  endtask

  task automatic clear_flags();
    clrFlags = 1'b1;
    step();
    clrFlags  = 1'b0;
    model_rej = 1'b0;
    check_eq("clr_rej", rejected, model_rej);
    $display("clrFlags rejected=%0b", rejected);
  endtask

  initial begin
    sysReset_n = 1'b0;
    wrStrobe   = 1'b0;
    wrChannel  = '0;
    wrData     = '0;
    clrFlags   = 1'b0;
    model_rej  = 1'b0;
    for (int n = 0; n < NCH; n++) model_last[n] = '0;
    repeat (3) @(posedge sysClk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rej", rejected, 1'b0);
    check_eq("rst_last", lastValue, '0);
    check_eq("rst_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, '0);
    #2 sysReset_n = 1'b1;
    repeat (3) step();

    run_xfer(2'd0, 16'hA5C3, -1, -1, -1);
    run_xfer(2'd1, 16'h0001, -1, -1, -1);
    run_xfer(2'd0, DW'($urandom), 50, -1, -1);
    check_eq("rej_after_busy", rejected, 1'b1);
    clear_flags();
    run_xfer(2'd1, DW'($urandom), 50, 50, -1);
    check_eq("rej_set_wins", rejected, 1'b1);
    run_xfer(2'd0, DW'($urandom), -1, 30, -1);
    check_eq("rej_cleared", rejected, 1'b0);
    bad_channel(2'd2);
    bad_channel(2'd3);
    clear_flags();
    run_xfer(2'd1, DW'($urandom), -1, -1, 80);
    run_xfer(2'd0, DW'($urandom), -1, -1, -1);

    // Back-to-back transfers with random data, lanes and flag traffic.
    for (int t = 0; t < 8; t++) begin
      int r = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, BUSY_LEN - 1)) : -1;
      int c = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, BUSY_LEN - 1)) : -1;
      run_xfer(2'($urandom_range(0, NCH - 1)), DW'($urandom), r, c, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/afe_attn_spi_driver.md
Name: afe_attn_spi_driver

Overview:
- Serial driver for the analogue front-end attenuator/switch shift registers on the AFE_SPI_CLK/SDI/LE board pins, one lane per AFE channel.
- Sits directly upstream of those top-level outputs and is fed by a sysClk-domain CSR write.
- One shared shift engine serialises a word MSB-first to the selected lane, then pulses that lane's latch enable.
- Reports busy, a sticky reject flag, and the last value committed to each lane.

Parameters:
- CLK_RATE, 99999001, sysClk frequency in Hz.
- SPI_CLK_RATE, 10000000, target serial clock in Hz.
- HALF_TICKS, ceil(CLK_RATE/(2*SPI_CLK_RATE)), sysClk cycles per serial half-period; minimum 1 (value 5 at the defaults).
- DATA_WIDTH, 16, bits shifted per transfer.
- CHANNEL_COUNT, 2, number of AFE lanes.
- CHSEL_WIDTH, 1, width of the channel-select field.
- LE_HALF_PERIODS, 1, latch-enable pulse length in half-periods; minimum 1.

Ports:
- sysClk  in  1  block clock.
- sysReset_n  in  1  asynchronous, active-low reset.
- wrStrobe  in  1  single-cycle request to start a transfer.
- wrChannel  in  CHSEL_WIDTH  target lane.
- wrData  in  DATA_WIDTH  word to shift.
- clrFlags  in  1  single-cycle strobe; clears the sticky flags.
- busy  out  1  high while a transfer is in progress.
- rejected  out  1  sticky; a request was ignored.
- lastValue  out  CHANNEL_COUNT*DATA_WIDTH  last completed word per lane; lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- AFE_SPI_CLK  out  CHANNEL_COUNT  serial clock per lane.
- AFE_SPI_SDI  out  CHANNEL_COUNT  serial data per lane.
- AFE_SPI_LE  out  CHANNEL_COUNT  latch enable per lane.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0, lastValue 0, state IDLE, divider 0.
  - Reset mid-transfer aborts immediately: pins go low and LE is never pulsed.
- States: IDLE, SETUP, CLKH, CLKL, LATCH, GAP. The divider counts HALF_TICKS cycles per phase; LATCH lasts LE_HALF_PERIODS*HALF_TICKS cycles.
- Accept condition: wrStrobe high in IDLE with wrChannel < CHANNEL_COUNT. On the accepting edge:
  - capture the channel and data into shadow registers;
  - next cycle: busy=1, state SETUP, selected lane SDI = data[MSB], SCK low.
- Request rejected, with rejected set and no transfer started, when:
  - wrStrobe arrives while busy; or
  - wrStrobe carries an out-of-range channel.
- Bit sequence:
  - SETUP to CLKH: SCK rises (the slave samples on this edge).
  - CLKH to CLKL: SCK falls; SDI advances to the next bit.
  - After the last bit, SDI holds the LSB through CLKL.
  - The bit counter runs DATA_WIDTH-1 down to 0; after CLKL of bit 0, go to LATCH.
- LATCH: selected lane LE=1, SCK=0, SDI=0. Exit to GAP with LE=0.
- GAP: all pins low. On exit: lastValue[lane] updated with the shadow data, busy=0, state IDLE.
- Next accept: a new request is acceptable on the first IDLE cycle; there is no back-to-back merging.
- Non-selected lanes: SCK, SDI and LE stay 0 throughout a transfer.
- All pin outputs are registered, with no combinational path from inputs to pins.
- Busy duration: exactly HALF_TICKS*(2*DATA_WIDTH+LE_HALF_PERIODS+2) cycles. At the defaults this is 175 cycles.
- Sticky flags:
  - clrFlags clears rejected.
  - If clrFlags and a new rejection occur in the same cycle, rejected remains 1 (set wins).
- wrData and wrChannel changing during a transfer have no effect.

Test Plan:
- Defaults; wrStrobe with wrChannel=0, wrData=16'hA5C3 -> lane 0 sees 16 SCK rising edges at 10-cycle spacing, sampled SDI = A5C3 MSB-first, one LE pulse of 5 cycles after the last SCK fall; busy high for exactly 175 cycles; lastValue[15:0]=A5C3; lane 1 pins stay 0 throughout.
- wrChannel=1, wrData=16'h0001 -> lane 1 sampled word is 0001; lastValue[31:16]=0001; lastValue[15:0] unchanged.
- Second wrStrobe 50 cycles into a transfer -> that request is ignored, rejected=1, the in-flight word completes intact. clrFlags -> rejected=0. clrFlags coinciding with a new rejection -> rejected stays 1.
- wrChannel=2 with CHSEL_WIDTH=2 and CHANNEL_COUNT=2 -> no pin activity, busy stays 0, rejected=1.
- sysReset_n pulsed low at cycle 80 of a transfer -> all pins 0 asynchronously, no LE pulse, busy=0, lastValue=0. A new request after release completes normally.
- Back-to-back: wrStrobe on the first cycle busy is 0 -> accepted, busy rises the next cycle; both words are latched correctly.
